// File: rtl/sensor_cond_pkg.sv
// Shared thresholds, filter constants and widths for the sensor conditioning stage.
// FAST_SIM_EN shrinks the sample-strobe and pedal-timeout counters for short simulations.
package sensor_cond_pkg;

    localparam logic [11:0] TORQUE_MIN  = 12'h380;
    localparam logic [11:0] BATT_LOW    = 12'hA98;
    localparam logic [11:0] BATT_HYST   = 12'h040;
    localparam logic [11:0] BATT_CLR    = BATT_LOW + BATT_HYST;
    localparam logic [11:0] BRAKE_THRES = 12'h800;

`ifdef FAST_SIM_EN
    localparam int SMPL_BITS = 8;
    localparam int CAD_BITS  = 12;
`else
    localparam int SMPL_BITS = 16;
    localparam int CAD_BITS  = 22;
`endif

    localparam int CURR_SHIFT = 2;
    localparam int TORQ_SHIFT = 5;
    localparam int CURR_ACC_W = 12 + CURR_SHIFT;
    localparam int TORQ_ACC_W = 12 + TORQ_SHIFT;

    // Assist request above the torque dead-band, doubled and clipped to 12 bits.
    function automatic logic [11:0] calc_target(input logic [11:0] avg_torque);
        logic [12:0] dbl;
        if (avg_torque <= TORQUE_MIN) return 12'h000;
        dbl = {avg_torque - TORQUE_MIN, 1'b0};
        return dbl[12] ? 12'hFFF : dbl[11:0];
    endfunction

endpackage

// File: rtl/cadence_meas.sv
// Cadence synchronizer, rising-edge detect and saturating pedal-timeout counter.
module cadence_meas
    import sensor_cond_pkg::*;
#(
    parameter int CAD_W = CAD_BITS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cadence,
    output logic cad_rise,
    output logic not_pedaling
);

    logic             sync1_q, sync2_q, edge_q;
    logic             rise_d, rise_q;
    logic             np_d, np_q;
    logic [CAD_W-1:0] tmr_d, tmr_q;

    always_comb begin
        rise_d = sync2_q & ~edge_q;
        tmr_d  = tmr_q;
        // Clear takes priority over saturation so a late edge still restarts the timeout.
        if (rise_q)
            tmr_d = '0;
        else if (!(&tmr_q))
            tmr_d = tmr_q + 1'b1;
        np_d = &tmr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            rise_q  <= 1'b0;
            tmr_q   <= '1;
            np_q    <= 1'b1;
        end else begin
            sync1_q <= cadence;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            rise_q  <= rise_d;
            tmr_q   <= tmr_d;
            np_q    <= np_d;
        end
    end

    assign cad_rise     = rise_q;
    assign not_pedaling = np_q;

endmodule

// File: rtl/sensor_cond.sv
// Conditions A2D readings into filtered current/torque, status flags, target current and error.
// Counter widths default from the package (FAST_SIM_EN) and may be overridden per instance.
module sensor_cond
    import sensor_cond_pkg::*;
#(
    parameter int SMPL_W = SMPL_BITS,
    parameter int CAD_W  = CAD_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] batt,
    input  logic [11:0] curr,
    input  logic [11:0] brake,
    input  logic [11:0] torque,
    input  logic        cadence,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        not_pedaling,
    output logic        batt_low,
    output logic        brake_on,
    output logic [11:0] target_curr,
    output logic [12:0] error
);

    logic                  cad_rise;
    logic                  curr_smpl;
    logic [SMPL_W-1:0]     smpl_cnt_d, smpl_cnt_q;
    logic [CURR_ACC_W-1:0] curr_acc_d, curr_acc_q;
    logic [TORQ_ACC_W-1:0] torq_acc_d, torq_acc_q;
    logic                  batt_low_d, batt_low_q;
    logic                  brake_on_d, brake_on_q;
    logic [11:0]           target_d, target_q;
    logic [12:0]           error_d, error_q;

    cadence_meas #(.CAD_W(CAD_W)) u_cad (
        .clk          (clk),
        .rst_n        (rst_n),
        .cadence      (cadence),
        .cad_rise     (cad_rise),
        .not_pedaling (not_pedaling)
    );

    assign curr_smpl  = &smpl_cnt_q;
    assign avg_curr   = curr_acc_q[CURR_ACC_W-1:CURR_SHIFT];
    assign avg_torque = torq_acc_q[TORQ_ACC_W-1:TORQ_SHIFT];

    always_comb begin
        smpl_cnt_d = smpl_cnt_q + 1'b1;
        curr_acc_d = curr_acc_q;
        torq_acc_d = torq_acc_q;
        if (curr_smpl)
            curr_acc_d = curr_acc_q - (curr_acc_q >> CURR_SHIFT) + CURR_ACC_W'(curr);
        if (cad_rise)
            torq_acc_d = torq_acc_q - (torq_acc_q >> TORQ_SHIFT) + TORQ_ACC_W'(torque);
    end

    always_comb begin
        batt_low_d = batt_low_q;
        if (batt < BATT_LOW)
            batt_low_d = 1'b1;
        else if (batt >= BATT_CLR)
            batt_low_d = 1'b0;
        brake_on_d = (brake < BRAKE_THRES);

        target_d = 12'h000;
        if (!(not_pedaling || batt_low_q || brake_on_q))
            target_d = calc_target(avg_torque);

        // Error trails target by one clock so both terms come from registered values.
        error_d = 13'h0000;
        if (!(brake_on_q || batt_low_q))
            error_d = {1'b0, target_q} - {1'b0, avg_curr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpl_cnt_q <= '0;
            curr_acc_q <= '0;
            torq_acc_q <= '0;
            batt_low_q <= 1'b0;
            brake_on_q <= 1'b0;
            target_q   <= 12'h000;
            error_q    <= 13'h0000;
        end else begin
            smpl_cnt_q <= smpl_cnt_d;
            curr_acc_q <= curr_acc_d;
            torq_acc_q <= torq_acc_d;
            batt_low_q <= batt_low_d;
            brake_on_q <= brake_on_d;
            target_q   <= target_d;
            error_q    <= error_d;
        end
    end

    assign batt_low    = batt_low_q;
    assign brake_on    = brake_on_q;
    assign target_curr = target_q;
    assign error       = error_q;

endmodule

// File: tb/tb_sensor_cond.sv
// Randomized self-checking bench for sensor_cond against an integer reference model.
module tb_sensor_cond;

    localparam int SMPL_W  = 8;
    localparam int CAD_W   = 12;
    localparam int CAD_MAX = (1 << CAD_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] batt = 12'h000, curr = 12'h000, brake = 12'hFFF, torque = 12'h000;
    logic        cadence = 1'b0;
    logic [11:0] avg_curr, avg_torque, target_curr;
    logic        not_pedaling, batt_low, brake_on;
    logic [12:0] error;
    logic [51:0] obs;

    int vecs = 0;
    int errs = 0;

    sensor_cond #(.SMPL_W(SMPL_W), .CAD_W(CAD_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .batt         (batt),
        .curr         (curr),
        .brake        (brake),
        .torque       (torque),
        .cadence      (cadence),
        .avg_curr     (avg_curr),
        .avg_torque   (avg_torque),
        .not_pedaling (not_pedaling),
        .batt_low     (batt_low),
        .brake_on     (brake_on),
        .target_curr  (target_curr),
        .error        (error)
    );

    always #5 clk = ~clk;

    assign obs = {avg_curr, avg_torque, not_pedaling, batt_low, brake_on, target_curr, error};

    // Reference model: plain integer arithmetic on the filter/threshold rules, with the
    // cadence path seen as a sample history (update 3 edges after a sampled 0->1).
    int m_edges = 0;
    int m_cad_hist[5] = '{0, 0, 0, 0, 0};
    int m_cacc = 0, m_tacc = 0, m_since = CAD_MAX, m_tgt = 0, m_err = 0;
    bit m_np = 1'b1, m_bl = 1'b0, m_bo = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_edges = 0; m_cad_hist = '{0, 0, 0, 0, 0};
            m_cacc = 0; m_tacc = 0; m_since = CAD_MAX; m_tgt = 0; m_err = 0;
            m_np = 1'b1; m_bl = 1'b0; m_bo = 1'b0;
        end else begin
            int n_tgt, n_err, at;
            bit upd_t;
            m_edges++;
            for (int i = 4; i > 0; i--) m_cad_hist[i] = m_cad_hist[i-1];
            m_cad_hist[0] = int'(cadence);
            upd_t = (m_cad_hist[3] == 1) && (m_cad_hist[4] == 0);

            n_err = (m_bo || m_bl) ? 0 : m_tgt - m_cacc / 4;
            at = m_tacc / 32;
            if (m_np || m_bl || m_bo || at <= 'h380) n_tgt = 0;
            else begin
                n_tgt = (at - 'h380) * 2;
                if (n_tgt > 4095) n_tgt = 4095;
            end

            if (m_edges % (1 << SMPL_W) == 0) m_cacc = m_cacc - m_cacc / 4 + int'(curr);
            if (upd_t) begin
                m_tacc  = m_tacc - m_tacc / 32 + int'(torque);
                m_since = 0;
            end else if (m_since < CAD_MAX) m_since++;
            m_np = (m_since == CAD_MAX);
            if (int'(batt) < 'hA98) m_bl = 1'b1;
            else if (int'(batt) >= 'hAD8) m_bl = 1'b0;
            m_bo = (int'(brake) < 'h800);
            m_tgt = n_tgt;
            m_err = n_err;
        end
    end

    function automatic logic [51:0] model_vec();
        logic [11:0] ac, at, tg;
        logic [12:0] er;
        ac = 12'(m_cacc / 4);
        at = 12'(m_tacc / 32);
        tg = 12'(m_tgt);
        er = 13'(m_err);
        return {ac, at, m_np, m_bl, m_bo, tg, er};
    endfunction

    task automatic test_reset();
        logic [51:0] exp;
        exp = 52'h0;
        exp[27] = 1'b1;  // not_pedaling bit position
        batt = 12'h000; curr = 12'h000; brake = 12'hFFF; torque = 12'h000; cadence = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if (obs !== exp) begin errs++; $display("FAIL reset_state obs=%h exp=%h", obs, exp); end
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (batt_low !== 1'b1) begin errs++; $display("FAIL batt_low_after_reset got=%b want=1", batt_low); end
        repeat (4) @(negedge clk);
        vecs++;
        if ({not_pedaling, target_curr, error} !== {1'b1, 12'h000, 13'h0000}) begin
            errs++;
            $display("FAIL idle_outputs np=%b tgt=%h err=%h want np=1 tgt=0 err=0", not_pedaling, target_curr, error);
        end
        vecs++;
        if (obs !== model_vec()) begin errs++; $display("FAIL idle_model obs=%h exp=%h", obs, model_vec()); end
    endtask

    task automatic test_curr_filter();
        int d;
        batt = 12'hC00; curr = 12'h100;
        repeat (32 << SMPL_W) @(negedge clk);
        d = int'(avg_curr) - 'h100;
        vecs++;
        if (d < -1 || d > 1) begin errs++; $display("FAIL avg_curr_settle got=%h want=100+-1", avg_curr); end
        vecs++;
        if (batt_low !== 1'b0) begin errs++; $display("FAIL batt_low_clear got=%b want=0", batt_low); end
        vecs++;
        if (obs !== model_vec()) begin errs++; $display("FAIL curr_model obs=%h exp=%h", obs, model_vec()); end
    endtask

    task automatic test_batt_hyst();
        logic [11:0] lvl  [5] = '{12'hA98, 12'hA97, 12'hAB0, 12'hAD7, 12'hAD8};
        logic        want [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            batt = lvl[i];
            repeat (2) @(negedge clk);
            vecs++;
            if (batt_low !== want[i]) begin
                errs++;
                $display("FAIL batt_hyst batt=%h got=%b want=%b", lvl[i], batt_low, want[i]);
            end
        end
        batt = 12'hC00;
        @(negedge clk);
    endtask

    task automatic test_torque_assist();
        int d;
        torque = 12'h780; brake = 12'hFFF; batt = 12'hC00;
        for (int p = 0; p < 200; p++) begin
            cadence = 1'b1;
            repeat (20) @(negedge clk);
            cadence = 1'b0;
            repeat (180) @(negedge clk);
            if (p % 20 == 19) begin
                vecs++;
                if (obs !== model_vec()) begin errs++; $display("FAIL torque_model p=%0d obs=%h exp=%h", p, obs, model_vec()); end
            end
        end
        d = int'(avg_torque) - 'h780;
        vecs++;
        if (d < -16 || d > 0) begin errs++; $display("FAIL avg_torque_settle got=%h want~780", avg_torque); end
        d = int'(target_curr) - 'h800;
        vecs++;
        if (d < -32 || d > 0) begin errs++; $display("FAIL target_assist got=%h want~800", target_curr); end
        vecs++;
        if (not_pedaling !== 1'b0) begin errs++; $display("FAIL pedaling got=%b want=0", not_pedaling); end
    endtask

    task automatic test_brake();
        brake = 12'h100;
        @(negedge clk);
        vecs++;
        if (brake_on !== 1'b1) begin errs++; $display("FAIL brake_on got=%b want=1", brake_on); end
        @(negedge clk);
        vecs++;
        if ({target_curr, error} !== 25'h0) begin
            errs++;
            $display("FAIL brake_zero tgt=%h err=%h want 0 0", target_curr, error);
        end
        vecs++;
        if (obs !== model_vec()) begin errs++; $display("FAIL brake_model obs=%h exp=%h", obs, model_vec()); end
        brake = 12'hFFF;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic want_np [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        cadence = 1'b0;
        repeat (4200) @(negedge clk);
        vecs++;
        if ({not_pedaling, target_curr} !== {1'b1, 12'h000}) begin
            errs++;
            $display("FAIL timeout np=%b tgt=%h want np=1 tgt=0", not_pedaling, target_curr);
        end
        cadence = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vecs++;
            if (not_pedaling !== want_np[i]) begin
                errs++;
                $display("FAIL cad_latency clk=%0d got=%b want=%b", i + 1, not_pedaling, want_np[i]);
            end
        end
        cadence = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            batt   = 12'($urandom_range('hA80, 'hAF0));
            curr   = 12'($urandom);
            torque = 12'($urandom);
            brake  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'hFFF;
            if ($urandom_range(0, 15) == 0) cadence = ~cadence;
            @(negedge clk);
            vecs++;
            if (obs !== model_vec()) begin errs++; $display("FAIL random c=%0d obs=%h exp=%h", c, obs, model_vec()); end
        end
    endtask

    task automatic test_reset_mid();
        logic [51:0] exp;
        exp = 52'h0;
        exp[27] = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if (obs !== exp) begin errs++; $display("FAIL reset_mid obs=%h exp=%h", obs, exp); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vecs++;
        if (obs !== model_vec()) begin errs++; $display("FAIL post_reset_model obs=%h exp=%h", obs, model_vec()); end
    endtask

    initial begin
        test_reset();
        test_curr_filter();
        test_batt_hyst();
        test_torque_assist();
        test_brake();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
